// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   rx_state_e   : receiver FSM states
//   parity_err_f : parity check of a received word against the parity bit
//   *_MIN/_MAX   : legal parameter ranges, checked at elaboration
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  // Word is zero-extended to the widest legal width; padding does not
  // change the XOR.
  function automatic logic parity_err_f(input logic [DATA_BITS_MAX-1:0] data,
                                        input logic par_bit,
                                        input logic odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end for the UART receiver.
//   clk, rst : clock, synchronous active-high reset
//   rx_in    : asynchronous serial line (idle high)
//   tick_os  : oversampling tick
//   rxs      : 2-FF synchronised line
//   maj      : majority of the last three rxs samples taken on ticks,
//              valid on a tick cycle (includes the current rxs)
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic tick_os,
  output logic rxs,
  output logic maj
);

  logic meta;
  logic [1:0] taps;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      rxs  <= 1'b1;
      taps <= 2'b11;
    end else begin
      meta <= rx_in;
      rxs  <= meta;
      if (tick_os) taps <= {taps[0], rxs};
    end
  end

  // The 3-sample window is two stored ticks plus the live sample, so the
  // vote is available on the same tick as the third sample.
  assign maj = (taps[1] & taps[0]) | (taps[1] & rxs) | (taps[0] & rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (DATA_BITS, optional parity, 1/2 stop bits,
// OVERSAMPLE ticks per bit) with majority voting, false-start rejection
// and parity / framing / break reporting.
//   clk, rst   : clock, synchronous active-high reset
//   rx_in      : asynchronous serial line, idle high
//   tick_os    : one-clk oversampling pulse, OVERSAMPLE per bit
//   rx_data    : last received word (LSB first on the line)
//   rx_valid   : one-clk pulse with new rx_data and flags
//   parity_err : parity mismatch, valid with rx_valid
//   frame_err  : a stop bit sampled low, valid with rx_valid
//   break_det  : one-clk pulse on line break, together with rx_valid
//   busy       : receiver not in IDLE
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 tick_os,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS out of range");
  end
  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_cfg: OVERSAMPLE must be even and in range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("uart_rx_cfg: PARITY_EN/PARITY_ODD must be 0 or 1");
  end

  localparam int MID = OVERSAMPLE / 2;
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [TCW-1:0] TC_DEC  = TCW'(MID + 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);
  localparam logic           SC_LAST = 1'(STOP_BITS - 1);
  localparam logic           PAR_EN  = (PARITY_EN != 0);
  localparam logic           PAR_ODD = (PARITY_ODD != 0);

  rx_state_e            state, state_nxt;
  logic [TCW-1:0]       tc;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 rxs, maj;
  logic                 decide, bit_end, final_stop, frame_ferr, is_break;

  uart_rx_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .tick_os (tick_os),
    .rxs     (rxs),
    .maj     (maj)
  );

  assign decide     = tick_os && (tc == TC_DEC);
  assign bit_end    = tick_os && (tc == TC_LAST);
  assign final_stop = (state == STOP) && decide && (stop_cnt == SC_LAST);
  assign frame_ferr = ferr_acc | ~maj;
  assign is_break   = frame_ferr && (shreg == '0) && !(PAR_EN && par_bit);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (tick_os && !rxs) state_nxt = START;
      START: begin
        if (decide && maj) state_nxt = IDLE;      // false start
        else if (bit_end)  state_nxt = DATA;
      end
      DATA:     if (bit_end && bit_cnt == BC_LAST) state_nxt = PAR_EN ? PARITY : STOP;
      PARITY:   if (bit_end) state_nxt = STOP;
      // Frame ends mid final stop bit, leaving half a bit to resync.
      STOP:     if (final_stop) state_nxt = is_break ? BRK_WAIT : IDLE;
      BRK_WAIT: if (tick_os && rxs) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tc         <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_valid  <= 1'b0;
      break_det <= 1'b0;
      if (tick_os) begin
        // The detecting tick is tc=0 of the start bit, so START begins at 1.
        if (state_nxt == IDLE || state_nxt == BRK_WAIT) tc <= '0;
        else if (state == IDLE)                          tc <= TCW'(1);
        else if (tc == TC_LAST)                          tc <= '0;
        else                                             tc <= tc + 1'b1;

        case (state)
          IDLE: begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
          end
          DATA: begin
            if (decide)  shreg   <= {maj, shreg[DATA_BITS-1:1]};
            if (bit_end) bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: if (decide) par_bit <= maj;
          STOP: begin
            if (decide) ferr_acc <= frame_ferr;
            if (bit_end) stop_cnt <= 1'b1;
            if (final_stop) begin
              rx_data    <= shreg;
              frame_err  <= frame_ferr;
              parity_err <= PAR_EN && parity_err_f(DATA_BITS_MAX'(shreg), par_bit, PAR_ODD);
              rx_valid   <= 1'b1;
              break_det  <= is_break;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: next generation of the fixed 8N1 receiver. Adds configurable data width, optional parity, 1 or 2 stop bits, configurable oversampling, an input synchroniser, 3-sample majority voting, false-start rejection, and parity/framing/break reporting. It sits between the pad-side serial input and the byte-stream consumer, and is driven by the shared baud-tick generator.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, ticks per bit, even, legal 8..32
- PARITY_EN, 0, 1 = a parity bit follows the data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
- STOP_BITS, 1, number of stop bits, 1 or 2
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_in  in  1  asynchronous serial line, idle high
- tick_os  in  1  one-clk oversampling pulse, OVERSAMPLE per bit period
- rx_data  out  DATA_BITS  last received word, LSB first on line; reset 0
- rx_valid  out  1  one-clk pulse marking new rx_data and flags; reset 0
- parity_err  out  1  parity mismatch of the current word, valid with rx_valid; reset 0
- frame_err  out  1  any stop bit sampled low, valid with rx_valid; reset 0
- break_det  out  1  one-clk pulse on line-break detection; reset 0
- busy  out  1  high in any state other than IDLE; reset 0

## Operation
- rx_in passes through a 2-FF synchroniser; all logic uses the synchronised line `rxs`.
- MID = OVERSAMPLE/2. The tick counter `tc` counts 0..OVERSAMPLE-1 within each bit. Bit value = majority of `rxs` at tc = MID-1, MID and MID+1, decided at MID+1.
- States:
  - **IDLE**: on a tick with rxs=0, go to START with tc=0.
  - **START**: at the decision point, majority 1 → false start, return to IDLE with no outputs. Majority 0 → continue to the end of the bit, then DATA.
  - **DATA**: DATA_BITS bits, shifted LSB first into bit index 0..DATA_BITS-1. At tc = OVERSAMPLE-1: go to the next bit, or to PARITY if PARITY_EN, otherwise to STOP.
  - **PARITY**: one bit. parity_err = XOR(data, parity bit) ≠ PARITY_ODD.
  - **STOP**: STOP_BITS bits. A low decision on any stop bit sets frame_err.
- Frame end: the decision point of the final stop bit ends the frame. No wait to end of bit, which leaves half a bit of resync margin.
  - rx_data, parity_err and frame_err update on that same clk edge, and rx_valid pulses for exactly one clk.
  - rx_data updates even when errors are flagged.
  - parity_err is 0 when PARITY_EN=0.
- Break: frame_err set, all data bits 0, and parity bit 0 (if enabled). break_det pulses together with rx_valid. The FSM then enters BRK_WAIT and stays until a tick with rxs=1, then goes to IDLE. No start detection occurs in BRK_WAIT.
- Outputs hold between frames. rx_valid and break_det are never high for more than one clk, independent of tick_os spacing.

## Timing
- Input latency: 2 clk from rx_in to rxs.
- Start detect to frame end: (1 + DATA_BITS + PARITY_EN + STOP_BITS − 1)·OVERSAMPLE + MID + 1 ticks, with the start tick at tc=0.
- State and counter advance only on tick_os cycles. Pulses are generated on the tick cycle and cleared on the next clk.
- Reset mid-frame: the next edge forces IDLE, tc=0, all outputs 0, and clears the synchroniser to 1. The partial frame is discarded with no pulse.
- tick_os held high continuously is legal; every clk is then a tick.

## Structure
- Package uart_pkg: state enumeration (IDLE, START, DATA, PARITY, STOP, BRK_WAIT), the parity function, and the legal-range constants for the parameters. Parameter legality is checked by elaboration-time assertions.
- Sub-module uart_rx_sampler: 2-FF synchroniser plus a 3-tap shift register of rxs on ticks, with a majority output. The FSM and counters stay in the top level.

## Test plan
- 8N1, OVERSAMPLE=16, send 0x55 then 0xA3 back-to-back with 1 stop → rx_data=0x55 then 0xA3, two single-clk rx_valid pulses, all error flags 0.
- Start glitch: rx_in low for 4 ticks, then high → no rx_valid, busy returns to 0, and a following 0x3C frame is received correctly.
- DATA_BITS=7, even parity, send 0x41 with parity bit 1 (wrong) → rx_data=0x41, parity_err=1, frame_err=0.
- STOP_BITS=2, second stop bit driven low, data 0xF0 → rx_data=0xF0, frame_err=1.
- Break: line held low for 3 frame times → one rx_valid with rx_data=0x00, frame_err=1, break_det=1. No further pulses until the line goes high, then 0x81 is received correctly.
- Noise and reset:
  - 1-tick spike inverted at tc=MID inside data bit 3 of 0xFF → rx_data=0xFF (majority).
  - rst asserted during bit 5 → all outputs 0 next clk, no rx_valid for that frame.
